// File: rtl/link_tx_arb_if.sv
// Host-link TX sequencer port bundle: request side, byte TX handshake and status.
// Latency: none, plain wires between the sequencer and its neighbours.
// Backpressure: carried by tx_byte_cmplt, one byte in flight at a time.
interface link_tx_arb_if #(
  parameter int N_CH = 6,
  parameter int BW   = 6
);
  logic            host_break;
  logic [N_CH-1:0] req;
  logic            rr_mode;
  logic            tx_byte_cmplt;
  logic            last_byte;
  logic            tx_byte_go;
  logic [N_CH-1:0] grant;
  logic            byte_addr_en;
  logic [BW-1:0]   byte_idx;
  logic [N_CH-1:0] pending;
  logic            busy;
  logic            wdt_timeout;
  logic            frame_err;

  // Requester / byte-TX side.
  modport master (
    output host_break, req, rr_mode, tx_byte_cmplt, last_byte,
    input  tx_byte_go, grant, byte_addr_en, byte_idx, pending, busy, wdt_timeout, frame_err
  );

  // Sequencer side.
  modport slave (
    input  host_break, req, rr_mode, tx_byte_cmplt, last_byte,
    output tx_byte_go, grant, byte_addr_en, byte_idx, pending, busy, wdt_timeout, frame_err
  );
endinterface

// File: rtl/link_tx_arb.sv
// Arbitrates sticky per-channel response requests onto a single byte transmitter.
// Latency: req -> pending 1 cycle, pending -> grant + tx_byte_go 1 cycle; all outputs registered.
// Backpressure: one byte in flight; next tx_byte_go only after tx_byte_cmplt, watchdog aborts a stall.
module link_tx_arb #(
  parameter int N_CH      = 6,
  parameter int WDT_LIMIT = 301,
  parameter int MAX_BYTES = 64,
  parameter int BW        = 6,
  parameter int GAP_CYC   = 4
) (
  input  logic         clk_25,
  input  logic         rst_n,
  link_tx_arb_if.slave bus
);
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WW = $clog2(WDT_LIMIT + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  state_t          state, state_nx;
  logic [WW-1:0]   wdt, wdt_nx;
  logic [GW-1:0]   gap_cnt, gap_nx;
  logic [SW-1:0]   rr_ptr, rr_nx;
  logic [BW-1:0]   byte_idx, idx_nx;
  logic [N_CH-1:0] pending, pend_clr;
  logic [N_CH-1:0] grant, grant_nx;
  logic            tx_byte_go, go_nx;
  logic            byte_addr_en, addr_nx;
  logic            wdt_timeout, tmo_nx;
  logic            frame_err, ferr_nx;
  logic            busy;
  logic            frame_end;
  logic [SW-1:0]   fix_sel, rr_sel, sel, cand;

  // Winner for each arbitration mode: lowest set index, or first set index after rr_ptr.
  always_comb begin
    fix_sel = '0;
    rr_sel  = '0;
    cand    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending[i]) fix_sel = SW'(i);
    end
    for (int k = N_CH; k >= 1; k--) begin
      cand = SW'((int'(rr_ptr) + k) % N_CH);
      if (pending[cand]) rr_sel = cand;
    end
  end

  assign sel = bus.rr_mode ? rr_sel : fix_sel;

  // Next-state and next-output decision; host_break overrides every state.
  always_comb begin
    state_nx  = state;
    wdt_nx    = wdt;
    gap_nx    = gap_cnt;
    rr_nx     = rr_ptr;
    idx_nx    = byte_idx;
    pend_clr  = '0;
    grant_nx  = '0;
    go_nx     = 1'b0;
    addr_nx   = 1'b0;
    tmo_nx    = 1'b0;
    ferr_nx   = 1'b0;
    frame_end = 1'b0;
    if (bus.host_break) begin
      state_nx = IDLE;
      wdt_nx   = '0;
      gap_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            grant_nx[sel] = 1'b1;
            pend_clr[sel] = 1'b1;
            go_nx         = 1'b1;
            idx_nx        = '0;
            rr_nx         = sel;
            wdt_nx        = '0;
            state_nx      = SEND;
          end
        end
        SEND: begin
          if (wdt == WW'(WDT_LIMIT)) begin
            tmo_nx    = 1'b1;
            frame_end = 1'b1;
          end else if (bus.tx_byte_cmplt && bus.last_byte) begin
            frame_end = 1'b1;
          end else if (bus.tx_byte_cmplt && (byte_idx == BW'(MAX_BYTES - 1))) begin
            ferr_nx   = 1'b1;
            frame_end = 1'b1;
          end else if (bus.tx_byte_cmplt) begin
            go_nx   = 1'b1;
            addr_nx = 1'b1;
            idx_nx  = byte_idx + 1'b1;
            wdt_nx  = '0;
          end else if (wdt < WW'(WDT_LIMIT)) begin
            wdt_nx = wdt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            state_nx = IDLE;
            gap_nx   = '0;
          end else begin
            gap_nx = gap_cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
      // A zero-length gap drops straight back to IDLE.
      if (frame_end) begin
        state_nx = (GAP_CYC == 0) ? IDLE : GAP;
        gap_nx   = '0;
      end
    end
  end

  // State register, counters and registered outputs.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wdt          <= '0;
      gap_cnt      <= '0;
      rr_ptr       <= SW'(N_CH - 1);
      byte_idx     <= '0;
      grant        <= '0;
      tx_byte_go   <= 1'b0;
      byte_addr_en <= 1'b0;
      wdt_timeout  <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      wdt          <= wdt_nx;
      gap_cnt      <= gap_nx;
      rr_ptr       <= rr_nx;
      byte_idx     <= idx_nx;
      grant        <= grant_nx;
      tx_byte_go   <= go_nx;
      byte_addr_en <= addr_nx;
      wdt_timeout  <= tmo_nx;
      frame_err    <= ferr_nx;
      busy         <= (state_nx != IDLE);
    end
  end

  // Sticky request flags; a new request beats the clear of the channel being granted.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~pend_clr) | bus.req;
  end

  assign bus.tx_byte_go   = tx_byte_go;
  assign bus.grant        = grant;
  assign bus.byte_addr_en = byte_addr_en;
  assign bus.byte_idx     = byte_idx;
  assign bus.pending      = pending;
  assign bus.busy         = busy;
  assign bus.wdt_timeout  = wdt_timeout;
  assign bus.frame_err    = frame_err;
endmodule
